fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of one synchronous FIFO (64-bit, depth 16) among NUM_REQ producers.
- Grants round-robin with burst lock, so a producer's packet lands contiguously in the FIFO.
- Sits between the PE-array / memory-read streams and the output staging FIFO.
- Gates new grants on FIFO almost_full; gates every beat on FIFO write_ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 64, beat width; must match the FIFO.
- BURST_LEN, 8, maximum beats per grant before forced release (1..256).
- ID_WIDTH, clog2(NUM_REQ) (min 1), grant index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester end-of-packet, qualified by valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_write_req  out  1  to FIFO s_write_req.
- fifo_write_data  out  DATA_WIDTH  to FIFO s_write_data.
- fifo_write_ready  in  1  from FIFO s_write_ready (not full).
- fifo_almost_full  in  1  from FIFO almost_full.
- grant_id  out  ID_WIDTH  current owner; valid while busy.
- busy  out  1  high in state LOCK.

Behaviour:
- Reset values: state IDLE, busy 0, grant_id 0, beat_cnt 0, rr_ptr NUM_REQ-1 (requester 0 wins first), req_ready 0, fifo_write_req 0.
- FSM IDLE:
  - If any req_valid and !fifo_almost_full, select the first valid index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Register grant_id, set rr_ptr = winner, clear beat_cnt, go to LOCK.
  - Otherwise stay in IDLE.
  - No beat transfers in IDLE; grant latency is 1 cycle from req_valid.
- FSM LOCK (combinational from registered grant_id):
  - fifo_write_data = req_data[grant_id].
  - fifo_write_req = req_valid[grant_id] & fifo_write_ready.
  - req_ready[grant_id] = fifo_write_ready; all other req_ready bits 0.
  - Beat = req_valid[grant_id] & fifo_write_ready. fifo_write_req is never asserted when fifo_write_ready is 0, so no FIFO write is ever dropped.
  - On a beat: beat_cnt increments (width clog2(BURST_LEN)+1).
  - On a beat with req_last[grant_id], or with beat_cnt == BURST_LEN-1: release, go to IDLE, busy drops next cycle.
- Release always costs one IDLE cycle, i.e. one dead cycle between grants.
- Owner drops valid mid-packet: grant is held indefinitely, no timeout; other requesters wait.
- fifo_almost_full rising during LOCK: burst continues, limited only by fifo_write_ready.
- FIFO full during LOCK: stall with req_ready 0; beat_cnt unchanged.
- Non-granted requesters: valid/data/last are ignored; they must hold their beat until ready.
- Reset mid-burst: immediate return to reset values; partially written packets are not rolled back.
- BURST_LEN == 1: every beat releases.

Optional Feature:
- Macro: FIFO_WRITE_ARB_STATS_EN.
- When defined, adds output stall_cycles (32 bits). It counts cycles in LOCK with req_valid[grant_id]=1 and fifo_write_ready=0, saturates at 0xFFFFFFFF, and clears on reset.
- When undefined, the port and the counter are absent and all other behaviour is identical.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding ARB_IDLE=1'b0, ARB_LOCK=1'b1;
  - function clog2;
  - constant STALL_CNT_WIDTH=32.
- One natural sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: valid vector, rr_ptr.
  - Outputs: found, index.
  - Implemented as a doubled-vector mask search; reusable by other arbiters.

Test Plan:
- Single requester:
  - Stimulus: reset, then requester 2 sends 3 beats (0xA0..0xA2, last on third) with fifo_write_ready=1.
  - Response: grant_id=2 one cycle after valid; three consecutive fifo_write_req pulses with data A0,A1,A2; busy low on the cycle after A2.
- Round-robin fairness:
  - Stimulus: all four valid continuously, each packet 1 beat with last=1.
  - Response: grant order 0,1,2,3,0,… with one dead cycle between grants (1 write per 2 cycles).
- Burst cap:
  - Stimulus: BURST_LEN=8; requester 1 sends a 12-beat packet while requester 3 is valid.
  - Response: 8 beats from 1, release, 3 granted next, then 1 resumes for its remaining 4 beats.
- FIFO backpressure:
  - Stimulus: fifo_write_ready low for 5 cycles mid-burst.
  - Response: no fifo_write_req and req_ready=0 during those cycles; beat_cnt frozen; data order preserved; with STATS_EN, stall_cycles=5.
- Almost-full gating:
  - Stimulus: fifo_almost_full=1 in IDLE with requests pending.
  - Response: state stays IDLE and no grant; grant occurs the cycle after almost_full deasserts.
- Reset mid-burst:
  - Stimulus: assert reset after beat 2 of requester 3's burst.
  - Response: next cycle busy=0, req_ready=0, fifo_write_req=0; first grant after reset goes to requester 0 if valid.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int STALL_CNT_WIDTH = 32;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals around the write arbiter.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
);
    import fifo_arb_pkg::*;

    localparam int ID_WIDTH = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_write_req;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic                          fifo_write_ready;
    logic                          fifo_almost_full;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_last, req_data, fifo_write_ready, fifo_almost_full,
        output req_ready, fifo_write_req, fifo_write_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_write_ready, fifo_almost_full,
        input  req_ready, fifo_write_req, fifo_write_data, grant_id, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of valid after rr_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    int             start;

    // Doubling the vector turns the wrap-around search into a plain shift.
    always_comb begin
        start   = int'(rr_ptr) + 1;
        doubled = {valid, valid};
        rotated = N'(doubled >> start);
        found   = 1'b0;
        index   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found = 1'b1;
                index = IDX_W'((start + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port among NUM_REQ producers.
// Define FIFO_WRITE_ARB_STATS_EN to add the saturating stall_cycles counter output.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    fifo_write_arbiter_if.master       bus
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
`endif
);

    localparam int ID_WIDTH  = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int CNT_WIDTH = clog2(BURST_LEN) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0] pick_index;
    logic                pick_found;
    logic                owner_valid;
    logic                owner_last;
    logic                beat;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_WIDTH)
    ) u_rr_pick (
        .valid  (bus.req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .index  (pick_index)
    );

    assign owner_valid = bus.req_valid[grant_id_q];
    assign owner_last  = bus.req_last[grant_id_q];
    assign beat        = (state_q == ARB_LOCK) && owner_valid && bus.fifo_write_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found && !bus.fifo_almost_full) begin
                    state_d    = ARB_LOCK;
                    grant_id_d = pick_index;
                    rr_ptr_d   = pick_index;
                    beat_cnt_d = '0;
                end
            end
            ARB_LOCK: begin
                // Release on end-of-packet or when the burst cap is reached.
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
                    if (owner_last || (beat_cnt_q == LAST_BEAT)) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.busy            = (state_q == ARB_LOCK);
        bus.grant_id        = grant_id_q;
        bus.fifo_write_data = bus.req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
        bus.fifo_write_req  = beat;
        bus.req_ready       = '0;
        if (state_q == ARB_LOCK) begin
            bus.req_ready[grant_id_q] = bus.fifo_write_ready;
        end
    end

`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((state_q == ARB_LOCK) && owner_valid && !bus.fifo_write_ready &&
            (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
